timer_prog_ctrl: RTL and testbench

Countdown-timer value source for the RTC VGA display. Holds the timer value as three packed-BCD registers (HH, MM, SS), lets the user edit each field while programming mode is active, and counts down once per second when started. Its outputs drive the timer-digit renderer directly: timer_in1/2/3 and the field-highlight address. It sits between the button/debounce front end, the 1 Hz tick generator and the VGA text path.

---
 rtl/timer_prog_ctrl.sv | 105 ++++++++++
 tb/tb_timer_prog_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/timer_prog_ctrl.sv
// timer_prog_ctrl: BCD HH:MM:SS countdown timer with field editing in programming mode.
module timer_prog_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       programar_on,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       start,
    input  logic       alarm_ack,
    output logic [7:0] timer_hh,
    output logic [7:0] timer_mm,
    output logic [7:0] timer_ss,
    output logic [3:0] direccion_actual,
    output logic       running,
    output logic       alarm
);
    typedef enum logic [2:0] {IDLE, RUN, PAUSE, DONE, PROG} state_t;
    state_t state, next_state;
    logic [3:0] cursor, next_cursor, dir_d;
    logic [7:0] hh_n, mm_n, ss_n, dhh, dmm, dss;
    logic is_zero, is_one, tick_run, edit, up, dn, run_d, alarm_d;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        return v == max ? 8'h00 : v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        return v == 8'h00 ? max : v[3:0] == 4'h0 ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
    endfunction

    assign is_zero  = {timer_hh, timer_mm, timer_ss} == 24'h000000;
    assign is_one   = {timer_hh, timer_mm, timer_ss} == 24'h000001;
    assign tick_run = state == RUN && !programar_on && tick_1hz;
    assign edit     = state == PROG && programar_on;
    assign up       = btn_up & ~btn_down;
    assign dn       = btn_down & ~btn_up;

    // one-second step with borrow chain SS -> MM -> HH
    assign dss = bcd_dec(timer_ss, 8'h59);
    assign dmm = timer_ss == 8'h00 ? bcd_dec(timer_mm, 8'h59) : timer_mm;
    assign dhh = (timer_ss == 8'h00 && timer_mm == 8'h00) ? bcd_dec(timer_hh, 8'h23) : timer_hh;

    always_comb begin
        hh_n = timer_hh;
        mm_n = timer_mm;
        ss_n = timer_ss;
        if (tick_run) begin
            hh_n = dhh;
            mm_n = dmm;
            ss_n = dss;
        end else if (edit && (up || dn)) begin
            if (cursor == 4'd6) hh_n = up ? bcd_inc(timer_hh, 8'h23) : bcd_dec(timer_hh, 8'h23);
            if (cursor == 4'd7) mm_n = up ? bcd_inc(timer_mm, 8'h59) : bcd_dec(timer_mm, 8'h59);
            if (cursor == 4'd8) ss_n = up ? bcd_inc(timer_ss, 8'h59) : bcd_dec(timer_ss, 8'h59);
        end
    end

    // cursor restarts on HH whenever programming mode is (re)entered
    assign next_cursor = state != PROG ? 4'd6 :
                         (btn_right && !btn_left) ? (cursor == 4'd8 ? 4'd6 : cursor + 4'd1) :
                         (btn_left && !btn_right) ? (cursor == 4'd6 ? 4'd8 : cursor - 4'd1) : cursor;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cursor           <= 4'd6;
            timer_hh         <= 8'h00;
            timer_mm         <= 8'h00;
            timer_ss         <= 8'h00;
            direccion_actual <= 4'd0;
            running          <= 1'b0;
            alarm            <= 1'b0;
        end else begin
            state            <= next_state;
            cursor           <= next_cursor;
            timer_hh         <= hh_n;
            timer_mm         <= mm_n;
            timer_ss         <= ss_n;
            direccion_actual <= dir_d;
            running          <= run_d;
            alarm            <= alarm_d;
        end
    end

    always_comb begin
        next_state = state;
        if (programar_on) next_state = PROG;
        else case (state)
            IDLE:    if (start && !is_zero) next_state = RUN;
            RUN:     if (tick_1hz && is_one) next_state = DONE; else if (start) next_state = PAUSE;
            PAUSE:   if (start) next_state = RUN;
            DONE:    if (alarm_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        run_d   = next_state == RUN;
        alarm_d = next_state == DONE;
        dir_d   = next_state == PROG ? next_cursor : 4'd0;
    end
endmodule

// File: tb/tb_timer_prog_ctrl.sv
// tb_timer_prog_ctrl: directed vector table plus random stimulus against a seconds-based model.
module tb_timer_prog_ctrl;
    logic clk = 0, reset = 0, tick_1hz = 0, programar_on = 0;
    logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, start = 0, alarm_ack = 0;
    logic [7:0] timer_hh, timer_mm, timer_ss;
    logic [3:0] direccion_actual;
    logic running, alarm;
    int checks = 0, errors = 0;
    int m_mode = 0, m_h = 0, m_m = 0, m_s = 0, m_cur = 0;

    localparam logic [8:0] R = 9'h100, P = 9'h080, U = 9'h040, D = 9'h020, L = 9'h010,
                           RT = 9'h008, S = 9'h004, T = 9'h002, A = 9'h001;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3, M_PROG = 4;

    typedef struct {
        logic [8:0]  in;
        logic [29:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    timer_prog_ctrl dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .programar_on(programar_on),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .start(start), .alarm_ack(alarm_ack), .timer_hh(timer_hh), .timer_mm(timer_mm),
        .timer_ss(timer_ss), .direccion_actual(direccion_actual), .running(running), .alarm(alarm)
    );

    function automatic logic [7:0] bcd(input int x);
        return 8'((x / 10) * 16 + x % 10);
    endfunction

    function automatic vec_t mk(input logic [8:0] in, input logic [7:0] hh, mm, ss,
                                input logic [3:0] dir, input logic run, al);
        vec_t v;
        v.in = in;
        v.exp = {hh, mm, ss, dir, run, al};
        return v;
    endfunction

    function automatic logic [29:0] model_out();
        return {bcd(m_h), bcd(m_m), bcd(m_s), m_mode == M_PROG ? 4'(6 + m_cur) : 4'd0,
                m_mode == M_RUN, m_mode == M_DONE};
    endfunction

    // value kept as plain hours/minutes/seconds; countdown works on total seconds
    task automatic model_step(input logic [8:0] in);
        int t;
        t = m_h * 3600 + m_m * 60 + m_s;
        if (in[8]) begin
            m_mode = M_IDLE; m_h = 0; m_m = 0; m_s = 0; m_cur = 0;
        end else if (in[7]) begin
            if (m_mode != M_PROG) begin
                m_mode = M_PROG;
                m_cur = 0;
            end else begin
                if (in[6] != in[5]) begin
                    if (m_cur == 0) m_h = (m_h + (in[6] ? 1 : 23)) % 24;
                    else if (m_cur == 1) m_m = (m_m + (in[6] ? 1 : 59)) % 60;
                    else m_s = (m_s + (in[6] ? 1 : 59)) % 60;
                end
                if (in[4] != in[3]) m_cur = (m_cur + (in[3] ? 1 : 2)) % 3;
            end
        end else if (m_mode == M_PROG) m_mode = M_IDLE;
        else if (m_mode == M_IDLE) begin
            if (in[2] && t > 0) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (in[1]) begin
                t--;
                m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
            end
            m_mode = (in[1] && t == 0) ? M_DONE : in[2] ? M_PAUSE : M_RUN;
        end else if (m_mode == M_PAUSE) begin
            if (in[2]) m_mode = M_RUN;
        end else if (in[0]) m_mode = M_IDLE;
    endtask

    task automatic cycle(input logic [8:0] in);
        {reset, programar_on, btn_up, btn_down, btn_left, btn_right, start, tick_1hz, alarm_ack} = in;
        @(posedge clk);
        model_step(in);
        #1;
        {reset, btn_up, btn_down, btn_left, btn_right, start, tick_1hz, alarm_ack} = '0;
    endtask

    task automatic check(input string name, input logic [29:0] exp);
        logic [29:0] act;
        act = {timer_hh, timer_mm, timer_ss, direccion_actual, running, alarm};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h:%h:%h dir=%0d run=%b alarm=%b, required %h:%h:%h dir=%0d run=%b alarm=%b",
                     name, act[29:22], act[21:14], act[13:6], act[5:2], act[1], act[0],
                     exp[29:22], exp[21:14], exp[13:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        logic [8:0] in;
        logic prog;
        vecs.push_back(mk(R,      8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(P,      8'h00, 8'h00, 8'h00, 6, 0, 0));
        vecs.push_back(mk(P|U,    8'h01, 8'h00, 8'h00, 6, 0, 0));
        vecs.push_back(mk(P|U,    8'h02, 8'h00, 8'h00, 6, 0, 0));
        vecs.push_back(mk(P|U,    8'h03, 8'h00, 8'h00, 6, 0, 0));
        vecs.push_back(mk(P|L,    8'h03, 8'h00, 8'h00, 8, 0, 0));
        vecs.push_back(mk(P|D,    8'h03, 8'h00, 8'h59, 8, 0, 0));
        vecs.push_back(mk(P|L,    8'h03, 8'h00, 8'h59, 7, 0, 0));
        vecs.push_back(mk(P|D,    8'h03, 8'h59, 8'h59, 7, 0, 0));
        vecs.push_back(mk(P|U,    8'h03, 8'h00, 8'h59, 7, 0, 0));
        vecs.push_back(mk(P|U|D,  8'h03, 8'h00, 8'h59, 7, 0, 0));
        vecs.push_back(mk(P|D|RT, 8'h03, 8'h59, 8'h59, 8, 0, 0));
        vecs.push_back(mk(P|L|RT, 8'h03, 8'h59, 8'h59, 8, 0, 0));
        vecs.push_back(mk(P|RT,   8'h03, 8'h59, 8'h59, 6, 0, 0));
        vecs.push_back(mk(P|D,    8'h02, 8'h59, 8'h59, 6, 0, 0));
        vecs.push_back(mk(P|D,    8'h01, 8'h59, 8'h59, 6, 0, 0));
        vecs.push_back(mk(P|L,    8'h01, 8'h59, 8'h59, 8, 0, 0));
        vecs.push_back(mk(P|U,    8'h01, 8'h59, 8'h00, 8, 0, 0));
        vecs.push_back(mk(P|L,    8'h01, 8'h59, 8'h00, 7, 0, 0));
        vecs.push_back(mk(P|U,    8'h01, 8'h00, 8'h00, 7, 0, 0));
        vecs.push_back(mk(0,      8'h01, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(S,      8'h01, 8'h00, 8'h00, 0, 1, 0));
        vecs.push_back(mk(T,      8'h00, 8'h59, 8'h59, 0, 1, 0));
        vecs.push_back(mk(S,      8'h00, 8'h59, 8'h59, 0, 0, 0));
        vecs.push_back(mk(T,      8'h00, 8'h59, 8'h59, 0, 0, 0));
        vecs.push_back(mk(T,      8'h00, 8'h59, 8'h59, 0, 0, 0));
        vecs.push_back(mk(S,      8'h00, 8'h59, 8'h59, 0, 1, 0));
        vecs.push_back(mk(T,      8'h00, 8'h59, 8'h58, 0, 1, 0));
        vecs.push_back(mk(T|S,    8'h00, 8'h59, 8'h57, 0, 0, 0));
        vecs.push_back(mk(R|S|T,  8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(S,      8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(P,      8'h00, 8'h00, 8'h00, 6, 0, 0));
        vecs.push_back(mk(P|L,    8'h00, 8'h00, 8'h00, 8, 0, 0));
        vecs.push_back(mk(P|U,    8'h00, 8'h00, 8'h01, 8, 0, 0));
        vecs.push_back(mk(P|U,    8'h00, 8'h00, 8'h02, 8, 0, 0));
        vecs.push_back(mk(0,      8'h00, 8'h00, 8'h02, 0, 0, 0));
        vecs.push_back(mk(S,      8'h00, 8'h00, 8'h02, 0, 1, 0));
        vecs.push_back(mk(T,      8'h00, 8'h00, 8'h01, 0, 1, 0));
        vecs.push_back(mk(T|S,    8'h00, 8'h00, 8'h00, 0, 0, 1));
        vecs.push_back(mk(T,      8'h00, 8'h00, 8'h00, 0, 0, 1));
        vecs.push_back(mk(S,      8'h00, 8'h00, 8'h00, 0, 0, 1));
        vecs.push_back(mk(A,      8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(S,      8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(P,      8'h00, 8'h00, 8'h00, 6, 0, 0));
        vecs.push_back(mk(P|D,    8'h23, 8'h00, 8'h00, 6, 0, 0));
        vecs.push_back(mk(P|U,    8'h00, 8'h00, 8'h00, 6, 0, 0));
        vecs.push_back(mk(P|L,    8'h00, 8'h00, 8'h00, 8, 0, 0));
        vecs.push_back(mk(P|L,    8'h00, 8'h00, 8'h00, 7, 0, 0));
        vecs.push_back(mk(P|L,    8'h00, 8'h00, 8'h00, 6, 0, 0));
        vecs.push_back(mk(0,      8'h00, 8'h00, 8'h00, 0, 0, 0));

        cycle(R);
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].in);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        prog = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) prog = ~prog;
            in = '0;
            in[8] = $urandom_range(0, 399) == 0;
            in[7] = prog;
            in[6] = $urandom_range(0, 3) == 0;
            in[5] = $urandom_range(0, 2) == 0;
            in[4] = $urandom_range(0, 5) == 0;
            in[3] = $urandom_range(0, 5) == 0;
            in[2] = $urandom_range(0, 9) == 0;
            in[1] = $urandom_range(0, 1) == 0;
            in[0] = $urandom_range(0, 7) == 0;
            cycle(in);
            check($sformatf("rand%0d", i), model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
